muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multiply/divide sequencer owning the HI/LO register pair for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU from the execute stage and runs a 32-step shift-add multiply or restoring divide on one shared adder. It writes the 64-bit result into HI/LO and raises a stall request that the hazard unit ORs into its stall/flush outputs while an instruction that reads HI/LO is in decode.

## Interface
- WIDTH, 32, operand width; HI/LO each WIDTH bits; step counter is clog2(WIDTH) bits.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- start_e  input  1  valid mul/div instruction in execute; sampled only in IDLE.
- op_e  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- src_a_e  input  WIDTH  rs operand (multiplicand / dividend).
- src_b_e  input  WIDTH  rt operand (multiplier / divisor).
- abort  input  1  kill the in-flight operation (exception/flush); HI/LO untouched.
- mthi_w, mtlo_w  input  1 each  MTHI/MTLO write-back strobes.
- mt_data_w  input  WIDTH  MTHI/MTLO data.
- hilo_rd_d  input  1  MFHI/MFLO/MTHI/MTLO/mul/div currently in decode.
- busy  output  1  operation in flight (state != IDLE).
- stall_hilo  output  1  busy & hilo_rd_d; routed to the hazard unit (stall_F, stall_D, flush_E).
- done  output  1  one-cycle pulse when HI/LO are updated.
- hi, lo  output  WIDTH each  architectural HI/LO registers.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with start_e=1: latch op; latch |src_a|, |src_b| for signed ops (two's-complement negate if MSB set), raw values otherwise. Latch neg_q = a[MSB]^b[MSB] and neg_r = a[MSB] for signed ops; both 0 for unsigned. Clear count; go to CALC.
- Divide by zero (op DIV/DIVU, src_b_e==0): go straight to FIX with lo=all ones, hi=src_a_e (raw); no sign fix.
- CALC multiply: 64-bit accumulator {P_hi, P_lo=multiplier}. Each step: if P_lo[0], P_hi += multiplicand (WIDTH+1-bit sum, carry kept); then shift {carry,P_hi,P_lo} right 1.
- CALC divide (restoring): {R,Q=dividend}. Each step: shift left 1; trial = R - divisor (WIDTH+1 bits). If non-negative, R=trial and Q[0]=1.
- count increments each CALC cycle. When count==WIDTH-1: go to FIX.
- FIX multiply: {hi,lo} = neg_q ? -{P_hi,P_lo} : {P_hi,P_lo}.
- FIX divide: lo = neg_q ? -Q : Q; hi = neg_r ? -R : R. DIV 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap, no trap).
- FIX always: done=1 next cycle; go to IDLE.
- MTHI/MTLO: apply in IDLE only when start_e=0. If start_e=1 in the same cycle, start wins and the mt write is dropped. Pipeline ordering (stall_hilo) guarantees mt writes never arrive while busy. A write that arrives while busy anyway is ignored.
- start_e while busy: ignored. This is a protocol violation; the bench flags it.
- abort: in any state, next state IDLE, count cleared, hi/lo/done unchanged (done=0). abort has priority over start_e and FIX completion.
- rst: state IDLE; hi=lo=0; busy=0; done=0; stall_hilo=0; count and datapath registers 0. Mid-operation rst discards the result.

## Timing
- All outputs are registered except stall_hilo, which is combinational from busy and hilo_rd_d.
- Start accepted at edge E0. CALC occupies edges E1..E32 (WIDTH=32). FIX edge E33 writes hi/lo. done is high for the cycle after E33, and busy is low from the same cycle.
- Latency from start edge to result visible: WIDTH+1 cycles = 33 cycles; busy high for 33 cycles.
- Divide by zero: start at E0, FIX at E1, result visible after E1; latency 1 cycle after the start edge.
- A new start_e may be accepted on the cycle done=1 (back-to-back, zero bubble).
- MFHI in decode while busy: stall_hilo=1 every cycle until busy drops. The instruction reads the new hi on the first non-stalled cycle.

## Test plan
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulse exactly 1 cycle, busy high exactly 33 cycles.
- MULT -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU 100/0 -> one cycle later lo=0xFFFFFFFF, hi=100, done pulses, busy high 1 cycle.
- hilo_rd_d held at 1 from the start edge -> stall_hilo=1 for all 33 busy cycles and 0 on the done cycle. A second start on the done cycle is accepted and its result is correct.
- abort at CALC count 10 -> busy=0 next cycle, hi/lo keep prior values, no done. Reset asserted mid-CALC -> hi=lo=0, state IDLE.
- mtlo_w with 0x1234 in IDLE -> lo=0x1234. mthi_w together with start_e -> mt write dropped, hi = multiply result.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if
// Groups the execute-stage request, write-back MTHI/MTLO and decode-stage
// hazard signals exchanged between the pipeline and the HI/LO sequencer.
//   master : pipeline side (drives requests, observes status and HI/LO)
//   slave  : muldiv_seq side
// Signals:
//   start_e, op_e, src_a_e, src_b_e : mul/div request from execute
//   abort                           : kill the in-flight operation
//   mthi_w, mtlo_w, mt_data_w       : MTHI/MTLO write-back
//   hilo_rd_d                       : HI/LO user currently in decode
//   busy, stall_hilo, done, hi, lo  : sequencer status and HI/LO contents
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start_e;
    logic [1:0]       op_e;
    logic [WIDTH-1:0] src_a_e;
    logic [WIDTH-1:0] src_b_e;
    logic             abort;
    logic             mthi_w;
    logic             mtlo_w;
    logic [WIDTH-1:0] mt_data_w;
    logic             hilo_rd_d;
    logic             busy;
    logic             stall_hilo;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start_e, op_e, src_a_e, src_b_e, abort,
        output mthi_w, mtlo_w, mt_data_w, hilo_rd_d,
        input  busy, stall_hilo, done, hi, lo
    );

    modport slave (
        input  start_e, op_e, src_a_e, src_b_e, abort,
        input  mthi_w, mtlo_w, mt_data_w, hilo_rd_d,
        output busy, stall_hilo, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq
// Iterative multiply/divide sequencer owning the architectural HI/LO pair.
// MULT/MULTU use 32-step shift-add, DIV/DIVU use 32-step restoring division;
// both iterate on a single shared WIDTH+1-bit adder. Signed operations run
// on magnitudes and the sign is applied in the FIX state.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : muldiv_seq_if slave modport (request, MTHI/MTLO, hazard, HI/LO)
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             op_div;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic [WIDTH-1:0] operand;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi;    // P_hi during multiply, remainder during divide
    logic [WIDTH-1:0] acc_lo;    // multiplier bits / quotient bits
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    // Operand magnitudes for the start cycle, and one iteration step of the
    // active operation. Divide reuses the adder as a subtractor (~divisor + 1);
    // since the partial remainder stays below the divisor, the shifted value
    // minus the divisor fits WIDTH+1 bits and sum[WIDTH] is a reliable borrow.
    always_comb begin
        is_signed = bus.op_e[0];
        a_neg     = is_signed & bus.src_a_e[WIDTH-1];
        b_neg     = is_signed & bus.src_b_e[WIDTH-1];
        a_abs     = a_neg ? -bus.src_a_e : bus.src_a_e;
        b_abs     = b_neg ? -bus.src_b_e : bus.src_b_e;

        r_shift   = {acc_hi, acc_lo[WIDTH-1]};
        add_a     = {1'b0, acc_hi};
        add_b     = '0;
        add_cin   = 1'b0;
        if (op_div) begin
            add_a   = r_shift;
            add_b   = ~{1'b0, operand};
            add_cin = 1'b1;
        end else if (acc_lo[0]) begin
            add_b   = {1'b0, operand};
        end
        sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};

        step_hi = sum[WIDTH:1];
        step_lo = {sum[0], acc_lo[WIDTH-1:1]};
        if (op_div) begin
            if (!sum[WIDTH]) begin
                step_hi = sum[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = r_shift[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end

        prod     = {acc_hi, acc_lo};
        prod_neg = -prod;
    end

    // Control FSM and datapath registers. abort overrides everything except
    // reset and leaves HI/LO alone; MTHI/MTLO only land in IDLE when no start
    // is being accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            operand  <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                state <= IDLE;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start_e) begin
                            op_div <= bus.op_e[1];
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            count  <= '0;
                            if (bus.op_e[1] && (bus.src_b_e == '0)) begin
                                // Divide by zero bypasses CALC with fixed result
                                div_zero <= 1'b1;
                                operand  <= '0;
                                acc_hi   <= bus.src_a_e;
                                acc_lo   <= '1;
                                state    <= FIX;
                            end else begin
                                div_zero <= 1'b0;
                                acc_hi   <= '0;
                                state    <= CALC;
                                if (bus.op_e[1]) begin
                                    operand <= b_abs;
                                    acc_lo  <= a_abs;
                                end else begin
                                    operand <= a_abs;
                                    acc_lo  <= b_abs;
                                end
                            end
                        end else begin
                            if (bus.mthi_w) begin
                                hi_q <= bus.mt_data_w;
                            end
                            if (bus.mtlo_w) begin
                                lo_q <= bus.mt_data_w;
                            end
                        end
                    end
                    CALC: begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        count  <= count + CW'(1);
                        if (count == LAST_STEP) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        if (div_zero) begin
                            hi_q <= acc_hi;
                            lo_q <= acc_lo;
                        end else if (op_div) begin
                            lo_q <= neg_q ? -acc_lo : acc_lo;
                            hi_q <= neg_r ? -acc_hi : acc_hi;
                        end else begin
                            {hi_q, lo_q} <= neg_q ? prod_neg : prod;
                        end
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.stall_hilo = bus.busy & bus.hilo_rd_d;
    assign bus.done       = done_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq
// Directed bench for muldiv_seq. Each accepted operation pushes its expected
// {hi,lo} into a scoreboard queue; a monitor pops and compares on every done
// pulse, and also flags done pulses with nothing pending and starts issued
// while the sequencer is busy.
module tb_muldiv_seq;
    localparam int WIDTH = 32;
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       name;
    } vec_t;

    logic clk;
    logic rst;
    int   assertCount = 0;
    int   failCount   = 0;
    logic [63:0] expQ[$];
    string       nameQ[$];

    muldiv_seq_if #(.WIDTH(WIDTH)) bus ();

    muldiv_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor sampling on the falling edge
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_done: got hi=0x%0h lo=0x%0h, expected no result",
                         bus.hi, bus.lo);
            end else begin
                automatic logic [63:0] exp = expQ.pop_front();
                automatic string nm = nameQ.pop_front();
                checkOutput(nm, {bus.hi, bus.lo}, exp);
            end
        end
        if (!rst && bus.start_e && bus.busy) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL start_while_busy: got start_e=1 busy=1, expected no start");
        end
    end

    // Issue one start on the next rising edge; optionally record the result
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [63:0] exp,
                                 input string name, input bit expectResult);
        bus.start_e = 1'b1;
        bus.op_e    = op;
        bus.src_a_e = a;
        bus.src_b_e = b;
        if (expectResult) begin
            expQ.push_back(exp);
            nameQ.push_back(name);
        end
        @(posedge clk);
        #1;
        bus.start_e = 1'b0;
        bus.mthi_w  = 1'b0;
        bus.mtlo_w  = 1'b0;
    endtask

    // Count cycles until busy drops, bounded
    task automatic waitIdle(input string name, output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({name, "_timeout"}, {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic runVec(input vec_t v);
        int n;
        applyStimulus(v.op, v.a, v.b, {v.hi, v.lo}, v.name, 1'b1);
        waitIdle(v.name, n);
        checkOutput({v.name, "_busy_cycles"}, 64'(n), 64'(v.cycles));
        checkOutput({v.name, "_done_high"}, {63'd0, bus.done}, 64'd1);
        @(posedge clk);
        #1;
        checkOutput({v.name, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[10];
        int   n;
        int   stallCycles;

        vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, "multu_max"};
        vecs[1] = '{OP_MULT,  32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, "mult_m7x3"};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, "div_m7d2"};
        vecs[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, "div_min_m1"};
        vecs[4] = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1,  "divu_by0"};
        vecs[5] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33, "divu_100d7"};
        vecs[6] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 33, "multu_2p32"};
        vecs[7] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33, "mult_m1xm1"};
        vecs[8] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, "div_7dm2"};
        vecs[9] = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1,  "div_m5_by0"};

        rst           = 1'b1;
        bus.start_e   = 1'b0;
        bus.op_e      = 2'b00;
        bus.src_a_e   = '0;
        bus.src_b_e   = '0;
        bus.abort     = 1'b0;
        bus.mthi_w    = 1'b0;
        bus.mtlo_w    = 1'b0;
        bus.mt_data_w = '0;
        bus.hilo_rd_d = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_hi", 64'(bus.hi), 64'd0);
        checkOutput("reset_lo", 64'(bus.lo), 64'd0);
        checkOutput("reset_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("reset_done", {63'd0, bus.done}, 64'd0);
        checkOutput("reset_stall", {63'd0, bus.stall_hilo}, 64'd0);
        rst           = 1'b0;
        bus.hilo_rd_d = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] MTLO in IDLE");
        bus.mtlo_w    = 1'b1;
        bus.mt_data_w = 32'h1234;
        @(posedge clk);
        #1;
        bus.mtlo_w = 1'b0;
        checkOutput("mtlo_lo", 64'(bus.lo), 64'h1234);
        checkOutput("mtlo_hi", 64'(bus.hi), 64'd0);

        $display("[TB] directed vectors");
        foreach (vecs[i]) runVec(vecs[i]);

        $display("[TB] stall and back-to-back");
        bus.hilo_rd_d = 1'b1;
        applyStimulus(OP_MULT, 32'd6, 32'd7, {32'd0, 32'd42}, "b2b_mult_6x7", 1'b1);
        n = 0;
        stallCycles = 0;
        while (bus.busy && n < 200) begin
            if (bus.stall_hilo) stallCycles++;
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("b2b_stall_cycles", 64'(stallCycles), 64'd33);
        checkOutput("b2b_stall_on_done", {63'd0, bus.stall_hilo}, 64'd0);
        checkOutput("b2b_done_high", {63'd0, bus.done}, 64'd1);
        bus.hilo_rd_d = 1'b0;
        applyStimulus(OP_DIVU, 32'd42, 32'd5, {32'd2, 32'd8}, "b2b_divu_42d5", 1'b1);
        waitIdle("b2b_second", n);
        checkOutput("b2b_second_cycles", 64'(n), 64'd33);
        @(posedge clk);
        #1;

        $display("[TB] abort at count 10");
        applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, "aborted", 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        checkOutput("abort_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("abort_done", {63'd0, bus.done}, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("abort_hilo_kept", {bus.hi, bus.lo}, {32'd2, 32'd8});

        $display("[TB] MTHI together with start");
        bus.mthi_w    = 1'b1;
        bus.mt_data_w = 32'hDEADBEEF;
        applyStimulus(OP_MULTU, 32'd3, 32'd5, {32'd0, 32'd15}, "mthi_with_start", 1'b1);
        waitIdle("mthi_with_start", n);
        checkOutput("mthi_dropped_hi", 64'(bus.hi), 64'd0);
        @(posedge clk);
        #1;
        bus.mthi_w    = 1'b1;
        bus.mt_data_w = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        bus.mthi_w = 1'b0;
        checkOutput("mthi_idle_hi", 64'(bus.hi), 64'hCAFEF00D);
        checkOutput("mthi_idle_lo", 64'(bus.lo), 64'd15);

        $display("[TB] reset mid-CALC");
        applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, "reset_mid", 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midreset_hilo", {bus.hi, bus.lo}, 64'd0);
        checkOutput("midreset_busy", {63'd0, bus.busy}, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("midreset_no_done", {63'd0, bus.done}, 64'd0);

        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
